aq_cp0_vsetvl_exec: RTL and testbench
=====================================

Name: aq_cp0_vsetvl_exec

Overview:
- Sequential vsetvl/vsetvli executor and vl/vtype state holder in CP0 special.
- Receives AVL and vtype operands from the IU interface (iui), decodes vtype and computes VLMAX.
- Produces the new vl, returns it to iui as rd write data, and updates the architectural vl/vtype registers.
- Three-state FSM; one instruction in flight at a time.

Parameters:
- VLEN, 128, vector register length in bits (power of 2, 64..1024).
- ELEN, 64, maximum element width in bits.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  reset, synchronous, active-low.
- iui_special_vsetvl  in  1  request valid, one-cycle pulse; sampled only in IDLE.
- iui_special_vsetvl_rs1  in  64  AVL operand.
- iui_special_vsetvl_rs2  in  12  vtype operand.
- iui_special_rs1_x0  in  1  rs1 field is x0.
- iui_special_rd_x0  in  1  rd field is x0.
- rtu_yy_xx_flush  in  1  pipeline flush; cancels an in-flight op.
- special_iui_vsetvl_busy  out  1  high when the FSM is not in IDLE.
- special_iui_vsetvl_cmplt  out  1  one-cycle completion pulse.
- special_iui_vsetvl_wdata  out  64  new vl, valid only with cmplt; 0 otherwise.
- special_regs_vstart_clr  out  1  pulse coincident with a committing cmplt.
- cp0_vpu_vl  out  64  architectural vl, zero-extended.
- cp0_vpu_vtype  out  64  architectural vtype; vill is bit 63.

Behaviour:
- Reset (cpurst_b low at a clock edge):
  - FSM goes to IDLE; busy, cmplt, wdata and vstart_clr are all 0.
  - cp0_vpu_vl is 0; cp0_vpu_vtype is 0x8000_0000_0000_0000 (vill set).
  - Reset wins over every other event, including an op in WB.
- FSM states:
  - IDLE: when iui_special_vsetvl=1, latch rs1, rs2, rs1_x0 and rd_x0, then go to CALC.
  - CALC: decode vtype, compute VLMAX and the new vl into registers, then go to WB.
  - WB: assert cmplt and wdata for this cycle; at the end of the cycle update vl/vtype, then go to IDLE.
  - Latency: a request in cycle N gives cmplt in cycle N+2; busy is high in N+1 and N+2.
- Flush:
  - rtu_yy_xx_flush in CALC or WB: go to IDLE next cycle; no cmplt, no vstart_clr, no register update.
  - Flush in IDLE in the same cycle as a request: the request is dropped.
- Requests arriving while busy are ignored. Upstream must not issue them.
- vtype decode (latched rs2):
  - vlmul = rs2[2:0]: 000=1, 001=2, 010=4, 011=8, 101=1/2, 110=1/4, 111=1/8; 100 is reserved.
  - vsew = rs2[5:3]: 000=8, 001=16, 010=32, 011=64; 1xx is reserved.
  - vta = rs2[6], vma = rs2[7].
- vill is set when any of the following holds:
  - vlmul is reserved, or vsew is reserved;
  - SEW > ELEN;
  - SEW > LMUL*ELEN (fractional LMUL case);
  - rs2[11:8] != 0.
- VLMAX = VLEN*LMUL/SEW. Compute it as shifts only, no divider.
- New vl when vill=0:
  - rs1_x0=0: vl = min(rs1, VLMAX), with rs1 compared as unsigned 64-bit.
  - rs1_x0=1 and rd_x0=0: vl = VLMAX.
  - rs1_x0=1 and rd_x0=1: vl is unchanged and only vtype is written; wdata = current vl.
- Result when vill=1: vl=0, vtype=0x8000_0000_0000_0000, wdata=0.
- Result when vill=0: vtype = {56'b0, rs2[7:0]}.
- special_regs_vstart_clr pulses in WB exactly when cmplt pulses.

Test Plan:
- All scenarios use VLEN=128, ELEN=64.
1. rs2=0x010 (SEW32, LMUL1), rs1=10, rs1_x0=0 at cycle N -> busy at N+1/N+2; cmplt and vstart_clr at N+2 with wdata=4; from N+3 cp0_vpu_vl=4 and cp0_vpu_vtype=0x010.
2. rs2=0x003 (SEW8, LMUL8): rs1=200 -> vl=128; then rs1=5 -> vl=5; then rs1=0xFFFF_FFFF_FFFF_FFFF -> vl=128.
3. Illegal vtype cases, each with rs1=7:
   - rs2=0x004 (reserved LMUL) -> wdata=0, vl=0, vtype=0x8000_0000_0000_0000.
   - rs2=0x01F (SEW64, LMUL1/8) -> same vill result.
   - rs2=0x100 -> same vill result.
4. rs1_x0=1, rd_x0=0, rs2=0x018 (SEW64) -> vl=2. Then rs1_x0=1, rd_x0=1, rs2=0x0C0 -> vl stays 2, wdata=2, vtype=0x0C0.
5. Flush in CALC with vl=4 beforehand -> no cmplt, no vstart_clr, vl=4 and vtype unchanged; busy=0 the next cycle. Repeat with flush in WB -> same result.
6. cpurst_b low during WB -> next cycle cmplt=0, busy=0, vl=0, vtype=0x8000_0000_0000_0000. A second request while busy -> ignored, exactly one cmplt.

Source files
------------

// File: rtl/aq_cp0_vsetvl_exec.sv
// vsetvl/vsetvli executor: decodes vtype, computes VLMAX and the new vl,
// returns it to the IU and holds the architectural vl/vtype registers.
module aq_cp0_vsetvl_exec #(
   parameter int unsigned VLEN = 128,
   parameter int unsigned ELEN = 64
) (
   input  logic        forever_cpuclk,
   input  logic        cpurst_b,
   input  logic        iui_special_vsetvl,
   input  logic [63:0] iui_special_vsetvl_rs1,
   input  logic [11:0] iui_special_vsetvl_rs2,
   input  logic        iui_special_rs1_x0,
   input  logic        iui_special_rd_x0,
   input  logic        rtu_yy_xx_flush,
   output logic        special_iui_vsetvl_busy,
   output logic        special_iui_vsetvl_cmplt,
   output logic [63:0] special_iui_vsetvl_wdata,
   output logic        special_regs_vstart_clr,
   output logic [63:0] cp0_vpu_vl,
   output logic [63:0] cp0_vpu_vtype
);

   localparam int unsigned ELEN_LOG2 = $clog2(ELEN);
   localparam logic [63:0] VTYPE_VILL = 64'h8000_0000_0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      WB   = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] rs1_q;
   logic [11:0] rs2_q;
   logic        rs1_x0_q, rd_x0_q;
   logic [63:0] res_vl_q, res_vl_d;
   logic [63:0] res_vtype_q, res_vtype_d;
   logic [63:0] vl_q, vtype_q;

   logic        load, calc_en, commit, cmplt;
   logic [1:0]  lmul_up, lmul_dn;
   logic [3:0]  div_sh;
   logic        vill;
   logic [63:0] vlmax;

   // FSM state register
   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // FSM next state and control strobes
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      calc_en = 1'b0;
      cmplt   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (iui_special_vsetvl && !rtu_yy_xx_flush) begin
               load    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (rtu_yy_xx_flush) begin
               state_d = IDLE;
            end else begin
               calc_en = 1'b1;
               state_d = WB;
            end
         end
         WB: begin
            cmplt   = !rtu_yy_xx_flush;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign commit = cmplt;

   // vtype decode and VLMAX as VLEN * 2^lmul_up / (8 * 2^vsew * 2^lmul_dn)
   always_comb begin
      lmul_up = 2'd0;
      lmul_dn = 2'd0;
      case (rs2_q[2:0])
         3'b001:  lmul_up = 2'd1;
         3'b010:  lmul_up = 2'd2;
         3'b011:  lmul_up = 2'd3;
         3'b101:  lmul_dn = 2'd1;
         3'b110:  lmul_dn = 2'd2;
         3'b111:  lmul_dn = 2'd3;
         default: ;
      endcase
      // log2(SEW / LMUL) for fractional LMUL, log2(SEW) otherwise
      div_sh = 4'd3 + 4'(rs2_q[4:3]) + 4'(lmul_dn);
      vill   = (rs2_q[2:0] == 3'b100) || rs2_q[5] || (div_sh > 4'(ELEN_LOG2))
               || (|rs2_q[11:8]);
      vlmax  = (64'(VLEN) << lmul_up) >> div_sh;
   end

   // new vl / vtype selection
   always_comb begin
      res_vl_d    = 64'd0;
      res_vtype_d = VTYPE_VILL;
      if (!vill) begin
         res_vtype_d = {56'd0, rs2_q[7:0]};
         if (!rs1_x0_q)     res_vl_d = (rs1_q < vlmax) ? rs1_q : vlmax;
         else if (!rd_x0_q) res_vl_d = vlmax;
         else               res_vl_d = vl_q;
      end
   end

   // operand latch and result registers
   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         rs1_q       <= 64'd0;
         rs2_q       <= 12'd0;
         rs1_x0_q    <= 1'b0;
         rd_x0_q     <= 1'b0;
         res_vl_q    <= 64'd0;
         res_vtype_q <= VTYPE_VILL;
      end else begin
         if (load) begin
            rs1_q    <= iui_special_vsetvl_rs1;
            rs2_q    <= iui_special_vsetvl_rs2;
            rs1_x0_q <= iui_special_rs1_x0;
            rd_x0_q  <= iui_special_rd_x0;
         end
         if (calc_en) begin
            res_vl_q    <= res_vl_d;
            res_vtype_q <= res_vtype_d;
         end
      end
   end

   // architectural vl/vtype, updated only by a completing op
   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         vl_q    <= 64'd0;
         vtype_q <= VTYPE_VILL;
      end else if (commit) begin
         vl_q    <= res_vl_q;
         vtype_q <= res_vtype_q;
      end
   end

   assign special_iui_vsetvl_busy  = (state_q != IDLE);
   assign special_iui_vsetvl_cmplt = cmplt;
   assign special_iui_vsetvl_wdata = cmplt ? res_vl_q : 64'd0;
   assign special_regs_vstart_clr  = cmplt;
   assign cp0_vpu_vl               = vl_q;
   assign cp0_vpu_vtype            = vtype_q;

endmodule

// File: tb/tb_aq_cp0_vsetvl_exec.sv
// Directed bench for aq_cp0_vsetvl_exec (VLEN=128, ELEN=64).
module tb_aq_cp0_vsetvl_exec;

   localparam logic [63:0] VILL = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        vsetvl;
   logic [63:0] rs1;
   logic [11:0] rs2;
   logic        rs1_x0, rd_x0, flush;
   logic        busy, cmplt, vstart_clr;
   logic [63:0] wdata, vl, vtype;

   int n_checks = 0;
   int n_errors = 0;

   aq_cp0_vsetvl_exec #(.VLEN(128), .ELEN(64)) dut (
      .forever_cpuclk           (clk),
      .cpurst_b                 (rst_b),
      .iui_special_vsetvl       (vsetvl),
      .iui_special_vsetvl_rs1   (rs1),
      .iui_special_vsetvl_rs2   (rs2),
      .iui_special_rs1_x0       (rs1_x0),
      .iui_special_rd_x0        (rd_x0),
      .rtu_yy_xx_flush          (flush),
      .special_iui_vsetvl_busy  (busy),
      .special_iui_vsetvl_cmplt (cmplt),
      .special_iui_vsetvl_wdata (wdata),
      .special_regs_vstart_clr  (vstart_clr),
      .cp0_vpu_vl               (vl),
      .cp0_vpu_vtype            (vtype)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one-cycle request; returns 1 time unit into the CALC cycle
   task automatic issue(input logic [63:0] a, input logic [11:0] t, input logic x0s, input logic x0d);
      rs1    = a;
      rs2    = t;
      rs1_x0 = x0s;
      rd_x0  = x0d;
      vsetvl = 1'b1;
      tick();
      vsetvl = 1'b0;
   endtask

   // full op with checks on CALC, WB and the following IDLE cycle
   task automatic run_op(input string tag, input logic [63:0] a, input logic [11:0] t,
                         input logic x0s, input logic x0d, input logic [63:0] exp_wd,
                         input logic [63:0] exp_vl, input logic [63:0] exp_vt);
      issue(a, t, x0s, x0d);
      check({tag, ".calc_busy"}, 64'(busy), 64'd1);
      check({tag, ".calc_cmplt"}, 64'(cmplt), 64'd0);
      tick();
      check({tag, ".wb_busy"}, 64'(busy), 64'd1);
      check({tag, ".wb_cmplt"}, 64'(cmplt), 64'd1);
      check({tag, ".wb_vclr"}, 64'(vstart_clr), 64'd1);
      check({tag, ".wb_wdata"}, wdata, exp_wd);
      tick();
      check({tag, ".idle_busy"}, 64'(busy), 64'd0);
      check({tag, ".idle_cmplt"}, 64'(cmplt), 64'd0);
      check({tag, ".vl"}, vl, exp_vl);
      check({tag, ".vtype"}, vtype, exp_vt);
   endtask

   initial begin
      int ncmplt;
      rst_b = 1'b0; vsetvl = 1'b0; rs1 = '0; rs2 = '0;
      rs1_x0 = 1'b0; rd_x0 = 1'b0; flush = 1'b0;
      tick(); tick();
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.cmplt", 64'(cmplt), 64'd0);
      check("rst.wdata", wdata, 64'd0);
      check("rst.vclr", 64'(vstart_clr), 64'd0);
      check("rst.vl", vl, 64'd0);
      check("rst.vtype", vtype, VILL);
      rst_b = 1'b1;
      tick();

      // basic SEW32 LMUL1, VLMAX=4
      run_op("t1", 64'd10, 12'h010, 1'b0, 1'b0, 64'd4, 64'd4, 64'h010);

      // SEW8 LMUL8, VLMAX=128
      run_op("t2a", 64'd200, 12'h003, 1'b0, 1'b0, 64'd128, 64'd128, 64'h003);
      run_op("t2b", 64'd5, 12'h003, 1'b0, 1'b0, 64'd5, 64'd5, 64'h003);
      run_op("t2c", 64'hFFFF_FFFF_FFFF_FFFF, 12'h003, 1'b0, 1'b0, 64'd128, 64'd128, 64'h003);

      // illegal vtype encodings
      run_op("t3a", 64'd7, 12'h004, 1'b0, 1'b0, 64'd0, 64'd0, VILL);
      run_op("t3pre", 64'd3, 12'h010, 1'b0, 1'b0, 64'd3, 64'd3, 64'h010);
      run_op("t3b", 64'd7, 12'h01F, 1'b0, 1'b0, 64'd0, 64'd0, VILL);
      run_op("t3pre2", 64'd3, 12'h010, 1'b0, 1'b0, 64'd3, 64'd3, 64'h010);
      run_op("t3c", 64'd7, 12'h100, 1'b0, 1'b0, 64'd0, 64'd0, VILL);

      // rs1=x0 forms
      run_op("t4a", 64'd99, 12'h018, 1'b1, 1'b0, 64'd2, 64'd2, 64'h018);
      run_op("t4b", 64'd99, 12'h0C0, 1'b1, 1'b1, 64'd2, 64'd2, 64'h0C0);
      // fractional LMUL1/2 with SEW8: VLMAX=8
      run_op("t4c", 64'd0, 12'h005, 1'b1, 1'b0, 64'd8, 64'd8, 64'h005);

      // flush in CALC
      run_op("t5pre", 64'd10, 12'h010, 1'b0, 1'b0, 64'd4, 64'd4, 64'h010);
      issue(64'd200, 12'h003, 1'b0, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t5a.busy", 64'(busy), 64'd0);
      check("t5a.cmplt", 64'(cmplt), 64'd0);
      check("t5a.vclr", 64'(vstart_clr), 64'd0);
      tick();
      check("t5a.vl", vl, 64'd4);
      check("t5a.vtype", vtype, 64'h010);

      // flush in WB
      issue(64'd200, 12'h003, 1'b0, 1'b0);
      tick();
      flush = 1'b1;
      #1;
      check("t5b.cmplt", 64'(cmplt), 64'd0);
      check("t5b.vclr", 64'(vstart_clr), 64'd0);
      check("t5b.wdata", wdata, 64'd0);
      tick();
      flush = 1'b0;
      check("t5b.busy", 64'(busy), 64'd0);
      check("t5b.vl", vl, 64'd4);
      check("t5b.vtype", vtype, 64'h010);

      // flush coincident with a request in IDLE drops it
      rs1 = 64'd200; rs2 = 12'h003; rs1_x0 = 1'b0; rd_x0 = 1'b0;
      vsetvl = 1'b1; flush = 1'b1;
      tick();
      vsetvl = 1'b0; flush = 1'b0;
      check("t5c.busy", 64'(busy), 64'd0);
      tick(); tick();
      check("t5c.vl", vl, 64'd4);

      // reset during WB
      issue(64'd200, 12'h003, 1'b0, 1'b0);
      tick();
      check("t6a.wb_cmplt", 64'(cmplt), 64'd1);
      rst_b = 1'b0;
      tick();
      rst_b = 1'b1;
      check("t6a.cmplt", 64'(cmplt), 64'd0);
      check("t6a.busy", 64'(busy), 64'd0);
      check("t6a.vl", vl, 64'd0);
      check("t6a.vtype", vtype, VILL);
      tick();

      // second request while busy is ignored
      ncmplt = 0;
      issue(64'd3, 12'h010, 1'b0, 1'b0);
      rs1 = 64'd100; rs2 = 12'h003;
      vsetvl = 1'b1;
      tick();
      vsetvl = 1'b0;
      check("t6b.wdata", wdata, 64'd3);
      for (int i = 0; i < 6; i++) begin
         if (cmplt) ncmplt++;
         tick();
      end
      check("t6b.ncmplt", 64'(ncmplt), 64'd1);
      check("t6b.vl", vl, 64'd3);
      check("t6b.vtype", vtype, 64'h010);
      check("t6b.busy", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
